// File: rtl/wide_add_sequencer_if.sv
// Handshake and adder-slice bus for the wide add sequencer.
// The sequencer takes the master side; the operand source, result sink and
// external slice adder together form the slave side.
interface wide_add_sequencer_if #(
  parameter int L  = 16,
  parameter int NW = 4
);
  localparam int W = L * NW;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [L-1:0] add_a;
  logic [L-1:0] add_b;
  logic         add_cin;
  logic [L-1:0] add_sum;
  logic         add_cout;
  logic         busy;

  modport master (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin, busy
  );

  modport slave (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin, busy
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Wide add sequencer: splits NW*L-bit operands into L-bit slices, feeds them
// LSB-first through an external combinational adder, ripples the carry through
// a register and returns the assembled sum plus final carry.
module wide_add_sequencer #(
  parameter int L  = 16,
  parameter int NW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wide_add_sequencer_if.master  bus
);
  localparam int W  = L * NW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_opa, r_opb, r_res;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic          w_last;
  logic [W-1:0]  w_ins;

  assign w_last = (r_idx == IW'(NW - 1));
  // New sum slice lands in the top L bits; NW shifts leave slice 0 at the bottom.
  assign w_ins  = W'(bus.add_sum) << (W - L);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and all handshake/adder outputs; adder inputs are zero outside RUN
  // and the result is only exposed in DONE so a partial sum never leaks.
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_sum   = '0;
    bus.out_cout  = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        bus.busy    = 1'b1;
        bus.add_a   = r_opa[L-1:0];
        bus.add_b   = r_opb[L-1:0];
        bus.add_cin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_sum   = r_res;
        bus.out_cout  = r_carry;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, per-slice shifting and carry chaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_opa   <= bus.in_a;
            r_opb   <= bus.in_b;
            r_carry <= bus.in_cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_res   <= (r_res >> L) | w_ins;
          r_carry <= bus.add_cout;
          r_opa   <= r_opa >> L;
          r_opb   <= r_opb >> L;
          r_idx   <= w_last ? '0 : r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with a behavioural 16-bit slice adder.
module tb_wide_add_sequencer;
  localparam int L  = 16;
  localparam int NW = 4;
  localparam int W  = L * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  wide_add_sequencer_if #(.L(L), .NW(NW)) bus();

  wide_add_sequencer #(.L(L), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational slice adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Bounded wait for out_valid; call at a post-edge sampling point.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Present operands for one cycle while IDLE; returns just after the accept edge.
  task automatic start_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 0; bus.out_ready = 1;
    rst = 1'b1;
    tick(); tick();
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl got rdy=%b busy=%b ov=%b want 1 0 0", bus.in_ready, bus.busy, bus.out_valid);
    end
    n_vec++;
    if (bus.out_sum !== '0 || bus.out_cout !== 1'b0 || bus.add_a !== '0 || bus.add_b !== '0 || bus.add_cin !== 1'b0) begin
      n_err++; $display("FAIL reset_data got sum=%h co=%b a=%h b=%h ci=%b want zeros", bus.out_sum, bus.out_cout, bus.add_a, bus.add_b, bus.add_cin);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_carry_ripple();
    bus.out_ready = 1;
    start_txn(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    n_vec++;
    if (bus.add_a !== 16'hFFFF || bus.add_b !== 16'h0001 || bus.add_cin !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL ripple_slice0 got a=%h b=%h ci=%b rdy=%b busy=%b want ffff 0001 0 0 1", bus.add_a, bus.add_b, bus.add_cin, bus.in_ready, bus.busy);
    end
    tick();
    n_vec++;
    if (bus.add_cin !== 1'b1 || bus.add_a !== 16'h0000) begin
      n_err++; $display("FAIL ripple_slice1 got a=%h ci=%b want 0000 1", bus.add_a, bus.add_cin);
    end
    tick(); tick();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL ripple_early got ov=%b want 0 after 3 edges", bus.out_valid);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 64'h0000_0000_0001_0000 || bus.out_cout !== 1'b0) begin
      n_err++; $display("FAIL ripple_result got ov=%b sum=%h co=%b want 1 0000000000010000 0", bus.out_valid, bus.out_sum, bus.out_cout);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL ripple_idle got ov=%b rdy=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_all_ones_cin();
    bit ok;
    int ci_hi = 0;
    bus.out_ready = 1;
    start_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    for (int i = 0; i < NW; i++) begin
      if (bus.add_cin === 1'b1) ci_hi++;
      tick();
    end
    n_vec++;
    if (ci_hi != NW) begin
      n_err++; $display("FAIL ones_cin_count got %0d want %0d", ci_hi, NW);
    end
    wait_valid(ok);
    n_vec++;
    if (!ok || bus.out_sum !== 64'h0 || bus.out_cout !== 1'b1) begin
      n_err++; $display("FAIL ones_cin_result got ok=%b sum=%h co=%b want 1 0 1", ok, bus.out_sum, bus.out_cout);
    end
    tick();
  endtask

  task automatic test_max_plus_max();
    bit ok;
    bus.out_ready = 1;
    start_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_valid(ok);
    n_vec++;
    if (!ok || bus.out_sum !== 64'hFFFF_FFFF_FFFF_FFFF || bus.out_cout !== 1'b1) begin
      n_err++; $display("FAIL max_max got ok=%b sum=%h co=%b want 1 ffffffffffffffff 1", ok, bus.out_sum, bus.out_cout);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    bus.out_ready = 0;
    start_txn(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    wait_valid(ok);
    n_vec++;
    if (!ok || bus.out_sum !== 64'h0 || bus.out_cout !== 1'b1) begin
      n_err++; $display("FAIL bp_result got ok=%b sum=%h co=%b want 1 0 1", ok, bus.out_sum, bus.out_cout);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 1 || i == 2);
      bus.in_a = 64'h5; bus.in_b = 64'h7;
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 64'h0 || bus.out_cout !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    bus.in_valid = 0;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    bus.out_ready = 1;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL bp_release got ov=%b rdy=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL bp_no_queue got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    bus.out_ready = 1;
    start_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.add_a !== '0 || bus.add_b !== '0 || bus.add_cin !== 1'b0) begin
      n_err++; $display("FAIL abort_async got busy=%b ov=%b rdy=%b a=%h b=%h ci=%b want 0 0 1 0 0 0",
                        bus.busy, bus.out_valid, bus.in_ready, bus.add_a, bus.add_b, bus.add_cin);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    start_txn(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    wait_valid(ok);
    n_vec++;
    if (!ok || bus.out_sum !== 64'h2222_2222_2222_2211 || bus.out_cout !== 1'b0) begin
      n_err++; $display("FAIL abort_after got ok=%b sum=%h co=%b want 1 2222222222222211 0", ok, bus.out_sum, bus.out_cout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    logic [W:0] exp;
    logic [W-1:0] a, b;
    logic ci;
    int n_acc = 0, n_res = 0, last_acc = -1, gap_bad = 0, val_bad = 0;
    bus.out_ready = 1;
    bus.in_valid  = 1;
    for (int cyc = 0; cyc < 120 && n_res < 8; cyc++) begin
      if (bus.out_valid === 1'b1) begin
        n_res++;
        if (exp_q.size() == 0) val_bad++;
        else begin
          exp = exp_q.pop_front();
          if ({bus.out_cout, bus.out_sum} !== exp) begin
            val_bad++;
            $display("FAIL b2b_value got %h want %h", {bus.out_cout, bus.out_sum}, exp);
          end
        end
      end
      if (bus.in_ready === 1'b1) begin
        if (n_acc < 8) begin
          a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = 1'($urandom_range(0, 1));
          bus.in_a = a; bus.in_b = b; bus.in_cin = ci;
          exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci});
          if (last_acc >= 0 && cyc - last_acc != NW + 2) gap_bad++;
          last_acc = cyc;
          n_acc++;
        end else bus.in_valid = 0;
      end
      tick();
    end
    bus.in_valid = 0;
    n_vec++;
    if (val_bad != 0) begin
      n_err++; $display("FAIL b2b_results got %0d bad results want 0", val_bad);
    end
    n_vec++;
    if (gap_bad != 0) begin
      n_err++; $display("FAIL b2b_spacing got %0d bad gaps want 0", gap_bad);
    end
    n_vec++;
    if (n_res != 8 || exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_count got %0d results %0d pending want 8 0", n_res, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_all_ones_cin();
    test_max_plus_max();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
